// File: rtl/alu.sv
// Single-cycle registered ALU: 16 opcodes, Z/C/V/N flags.
// Result, flags and valid are captured one clock after an accepted input.
module alu (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  oper,
   input  logic [3:0]  flags_in,
   output logic [31:0] result,
   output logic [3:0]  flags_out,
   output logic        out_valid
);

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3,
      OP_RSB = 4'd4,  OP_MUL = 4'd5,  OP_AND = 4'd6,  OP_ORR = 4'd7,
      OP_XOR = 4'd8,  OP_BIC = 4'd9,  OP_LSL = 4'd10, OP_LSR = 4'd11,
      OP_ASR = 4'd12, OP_ROL = 4'd13, OP_ROR = 4'd14, OP_CPY = 4'd15
   } op_t;

   logic [31:0] r_result;
   logic [3:0]  r_flags;
   logic        r_valid;

   logic [31:0] w_x;
   logic [31:0] w_y;
   logic        w_cin;
   logic [32:0] w_sum;
   logic        w_add_v;
   logic [4:0]  w_s;
   logic [4:0]  w_lidx;
   logic [4:0]  w_ridx;
   logic [31:0] w_mul;
   logic [31:0] w_res;
   logic        w_c;
   logic        w_v;
   logic        w_cin_flag;
   logic        w_vin_flag;

   assign w_cin_flag = flags_in[1];
   assign w_vin_flag = flags_in[2];
   assign w_s        = b[4:0];
   // Bit index of the last bit shifted out: 32-s for LSL, s-1 for LSR/ASR.
   assign w_lidx     = 5'd0 - w_s;
   assign w_ridx     = w_s - 5'd1;
   assign w_mul      = a * b;

   // All add/subtract forms share one adder: x + y + cin.
   always_comb begin
      w_x   = a;
      w_y   = b;
      w_cin = 1'b0;
      unique case (oper)
         OP_ADC: w_cin = w_cin_flag;
         OP_SUB: begin w_y = ~b; w_cin = 1'b1; end
         OP_SBC: begin w_y = ~b; w_cin = w_cin_flag; end
         OP_RSB: begin w_x = b; w_y = ~a; w_cin = 1'b1; end
         default: ;
      endcase
   end

   assign w_sum   = {1'b0, w_x} + {1'b0, w_y} + {32'd0, w_cin};
   assign w_add_v = (w_x[31] == w_y[31]) && (w_sum[31] != w_x[31]);

   always_comb begin
      w_res = a;
      w_c   = w_cin_flag;
      w_v   = w_vin_flag;
      unique case (oper)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB: begin
            w_res = w_sum[31:0];
            w_c   = w_sum[32];
            w_v   = w_add_v;
         end
         OP_MUL: w_res = w_mul;
         OP_AND: w_res = a & b;
         OP_ORR: w_res = a | b;
         OP_XOR: w_res = a ^ b;
         OP_BIC: w_res = a & ~b;
         OP_LSL: begin
            w_res = a << w_s;
            if (w_s != 5'd0) w_c = a[w_lidx];
         end
         OP_LSR: begin
            w_res = a >> w_s;
            if (w_s != 5'd0) w_c = a[w_ridx];
         end
         OP_ASR: begin
            w_res = $unsigned($signed(a) >>> w_s);
            if (w_s != 5'd0) w_c = a[w_ridx];
         end
         OP_ROL: w_res = (a << w_s) | (a >> (6'd32 - {1'b0, w_s}));
         OP_ROR: w_res = (a >> w_s) | (a << (6'd32 - {1'b0, w_s}));
         OP_CPY: w_res = b;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_result <= 32'd0;
         r_flags  <= 4'd0;
         r_valid  <= 1'b0;
      end else if (in_valid) begin
         r_result <= w_res;
         r_flags  <= {w_res[31], w_v, w_c, (w_res == 32'd0)};
         r_valid  <= 1'b1;
      end else begin
         r_valid  <= 1'b0;
      end
   end

   assign result    = r_result;
   assign flags_out = r_flags;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: hand-computed results and flags.
// Inputs change on the falling edge; outputs sampled #1 after the rising edge.
module tb_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  oper;
   logic [3:0]  flags_in;
   logic [31:0] result;
   logic [3:0]  flags_out;
   logic        out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   alu dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .oper      (oper),
      .flags_in  (flags_in),
      .result    (result),
      .flags_out (flags_out),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input logic [3:0] fl);
      @(negedge clk);
      in_valid = 1'b1;
      oper     = op;
      a        = va;
      b        = vb;
      flags_in = fl;
   endtask

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string tag, input logic [3:0] op,
                      input logic [31:0] va, input logic [31:0] vb,
                      input logic [3:0] fl, input logic [31:0] er,
                      input logic [3:0] ef);
      drive(op, va, vb, fl);
      sample();
      check({tag, ".res"}, result, er);
      check({tag, ".flg"}, {28'd0, flags_out}, {28'd0, ef});
      check({tag, ".vld"}, {31'd0, out_valid}, 32'd1);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      oper     = '0;
      flags_in = '0;
      sample();
      check("rst.res", result, 32'd0);
      check("rst.flg", {28'd0, flags_out}, 32'd0);
      check("rst.vld", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run("add_zc", 4'd0, 32'hFFFF_FFFF, 32'd1, 4'b0000, 32'd0, 4'b0011);
      idle();
      sample();
      check("add_zc.drop", {31'd0, out_valid}, 32'd0);
      check("add_zc.hold", result, 32'd0);

      run("add_nv", 4'd0, 32'h7FFF_FFFF, 32'd1, 4'b0000,
          32'h8000_0000, 4'b1100);
      run("sub",    4'd2, 32'd5, 32'd7, 4'b0000, 32'hFFFF_FFFE, 4'b1000);
      run("sbc",    4'd3, 32'd10, 32'd3, 4'b0000, 32'd6, 4'b0010);
      run("rsb",    4'd4, 32'd3, 32'd10, 4'b0000, 32'd7, 4'b0010);
      run("lsl1",   4'd10, 32'h8000_0001, 32'd1, 4'b0000, 32'd2, 4'b0010);
      run("lsl31",  4'd10, 32'd1, 32'd31, 4'b0010,
          32'h8000_0000, 4'b1000);
      run("asr",    4'd12, 32'h8000_0000, 32'd4, 4'b0000,
          32'hF800_0000, 4'b1000);
      run("lsr0",   4'd11, 32'h1234_5678, 32'd0, 4'b0010,
          32'h1234_5678, 4'b0010);
      run("lsr1",   4'd11, 32'h8000_0001, 32'd1, 4'b0000,
          32'h4000_0000, 4'b0010);
      run("adc",    4'd1, 32'd1, 32'd1, 4'b0010, 32'd3, 4'b0000);
      run("mul",    4'd5, 32'h0001_0000, 32'h0001_0000, 4'b0110,
          32'd0, 4'b0111);
      run("mul2",   4'd5, 32'd7, 32'd6, 4'b0000, 32'd42, 4'b0000);
      run("ror",    4'd14, 32'd1, 32'd1, 4'b0110, 32'h8000_0000, 4'b1110);
      run("rol",    4'd13, 32'h8000_0000, 32'd4, 4'b0000, 32'd8, 4'b0000);
      run("rol0",   4'd13, 32'hA5A5_0000, 32'd32, 4'b0000,
          32'hA5A5_0000, 4'b1000);
      run("bic",    4'd9, 32'h0000_FFFF, 32'h0000_00FF, 4'b0000,
          32'h0000_FF00, 4'b0000);
      run("xor",    4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000,
          32'd0, 4'b0001);

      // three consecutive accepted operations
      run("b2b_and", 4'd6, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000,
          32'h0000_F000, 4'b0000);
      run("b2b_orr", 4'd7, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000,
          32'h0000_FFF0, 4'b0000);
      run("b2b_cpy", 4'd15, 32'h1234_5678, 32'd0, 4'b0000,
          32'd0, 4'b0001);

      // idle with changing operands: outputs hold
      @(negedge clk);
      in_valid = 1'b0;
      oper     = 4'd7;
      a        = 32'hDEAD_BEEF;
      b        = 32'h1111_1111;
      flags_in = 4'hF;
      sample();
      sample();
      check("idle.res", result, 32'd0);
      check("idle.flg", {28'd0, flags_out}, 32'd1);
      check("idle.vld", {31'd0, out_valid}, 32'd0);

      // reset wins over a simultaneous valid input
      run("pre", 4'd0, 32'd40, 32'd2, 4'b0000, 32'd42, 4'b0000);
      drive(4'd0, 32'd1, 32'd1, 4'b0000);
      reset = 1'b1;
      sample();
      check("rstv.res", result, 32'd0);
      check("rstv.flg", {28'd0, flags_out}, 32'd0);
      check("rstv.vld", {31'd0, out_valid}, 32'd0);

      // reset right after an accepted op clears the pending valid
      drive(4'd0, 32'd5, 32'd5, 4'b0000);
      reset = 1'b0;
      sample();
      check("pre2.vld", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      sample();
      check("rst2.vld", {31'd0, out_valid}, 32'd0);
      check("rst2.res", result, 32'd0);
      idle();
      sample();
      check("post.vld", {31'd0, out_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
